// File: rtl/instr_pair_encoder_if.sv
// Field-bundle input stream and IMEM pair-write port of instr_pair_encoder.
// slave  : the encoder side (consumes bundles, drives the pair write).
// master : the producer / IMEM side (drives bundles and mem_ready).
interface instr_pair_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [11:0]       in_imm12;
    logic [19:0]       in_imm20;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data_a;
    logic [31:0]       mem_data_b;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm12, in_imm20, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_data_a, mem_data_b
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm12, in_imm20, mem_ready,
        output in_ready, mem_we, mem_addr, mem_data_a, mem_data_b
    );
endinterface

// File: rtl/instr_pair_encoder.sv
// instr_pair_encoder: re-encodes decoded instruction fields into 32-bit
// RISC-V words, packs consecutive words into A/B pairs and writes each pair
// to the dual-issue IMEM through a valid/ready port.
// Optional macro ENC_SELFCHECK_EN: re-decodes every encoded word and sets a
// sticky selfcheck_err on any round-trip mismatch. Without it the check
// logic is absent and selfcheck_err is tied low.
module instr_pair_encoder #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_pair_encoder_if.slave bus,
    input  logic                flush,
    output logic                flush_done,
    output logic [15:0]         illegal_cnt,
    output logic                selfcheck_err
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_HAVE_A = 1'b1;

    logic [31:0]       enc_word;
    logic              enc_legal;

    logic              s1_valid_reg;
    logic [31:0]       s1_word_reg;
    logic [0:0]        state_reg;
    logic [31:0]       slot_a_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       data_a_reg;
    logic [31:0]       data_b_reg;
    logic              flush_pend_reg;
    logic              pad_wait_reg;
    logic              flush_done_reg;
    logic [15:0]       illegal_cnt_reg;

    logic accept;
    logic in_ready_int;
    logic out_free;
    logic mem_fire;
    logic s1_take;
    logic pair_load;
    logic flush_idle;
    logic pad_load;
    logic empty_done;
    logic pad_done;

    // Output register can take a new pair when idle or when its pair leaves now.
    assign out_free   = !mem_we_reg || bus.mem_ready;
    assign mem_fire   = mem_we_reg && bus.mem_ready;
    // S1 always moves into slot A when the packer is empty; into slot B only
    // when the output register can take the completed pair.
    assign s1_take    = s1_valid_reg && ((state_reg == ST_EMPTY) || out_free);
    assign pair_load  = s1_valid_reg && (state_reg == ST_HAVE_A) && out_free;
    // A pending flush acts only once S1 has drained into the packer.
    assign flush_idle = flush_pend_reg && !s1_valid_reg;
    assign pad_load   = flush_idle && (state_reg == ST_HAVE_A) && out_free;
    assign empty_done = flush_idle && (state_reg == ST_EMPTY) && !pad_wait_reg;
    assign pad_done   = pad_wait_reg && mem_fire;

    assign in_ready_int = !flush_pend_reg && (!s1_valid_reg || s1_take);
    assign accept       = bus.in_valid && in_ready_int;

    assign bus.in_ready   = in_ready_int;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_data_a = data_a_reg;
    assign bus.mem_data_b = data_b_reg;
    assign flush_done     = flush_done_reg;
    assign illegal_cnt    = illegal_cnt_reg;

    // Field bundle to RISC-V word; immediates arrive in decode-function order.
    always_comb begin
        enc_word  = NOP_WORD;
        enc_legal = 1'b1;
        case (bus.in_op)
            OP_R:         enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                                      bus.in_funct3, bus.in_rd, bus.in_op};
            OP_LOAD, OP_I: enc_word = {bus.in_imm12, bus.in_rs1, bus.in_funct3,
                                       bus.in_rd, bus.in_op};
            OP_S:         enc_word = {bus.in_imm12[11:5], bus.in_rs2, bus.in_rs1,
                                      bus.in_funct3, bus.in_imm12[4:0], bus.in_op};
            OP_B:         enc_word = {bus.in_imm12[11], bus.in_imm12[9:4],
                                      bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                      bus.in_imm12[3:0], bus.in_imm12[10], bus.in_op};
            OP_JAL:       enc_word = {bus.in_imm20[19], bus.in_imm20[10:0],
                                      bus.in_imm20[11], bus.in_imm20[18:12],
                                      bus.in_rd, bus.in_op};
            default:      enc_legal = 1'b0;
        endcase
    end

    // Stage-1 register: holds one encoded word until the packer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_word_reg  <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_word_reg  <= enc_word;
        end else if (s1_take) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Packer FSM: first word of a pair parks in slot A, second completes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_EMPTY;
            slot_a_reg <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (s1_valid_reg) begin
                        slot_a_reg <= s1_word_reg;
                        state_reg  <= ST_HAVE_A;
                    end
                end
                default: begin
                    if (pair_load || pad_load)
                        state_reg <= ST_EMPTY;
                end
            endcase
        end
    end

    // Output register: holds a pair stable until IMEM accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            data_a_reg   <= '0;
            data_b_reg   <= '0;
        end else begin
            if (pair_load || pad_load) begin
                mem_we_reg <= 1'b1;
                data_a_reg <= slot_a_reg;
                data_b_reg <= pad_load ? NOP_WORD : s1_word_reg;
            end else if (mem_fire) begin
                mem_we_reg <= 1'b0;
            end
            // Pair index wraps naturally at 2^ADDR_W.
            if (mem_fire)
                mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
        end
    end

    // Flush tracking: pending flag, wait for the padded write, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_reg <= 1'b0;
            pad_wait_reg   <= 1'b0;
            flush_done_reg <= 1'b0;
        end else begin
            if (flush)
                flush_pend_reg <= 1'b1;
            else if (empty_done || pad_done)
                flush_pend_reg <= 1'b0;

            if (pad_load)
                pad_wait_reg <= 1'b1;
            else if (mem_fire)
                pad_wait_reg <= 1'b0;

            flush_done_reg <= empty_done || pad_done;
        end
    end

    // Saturating count of bundles accepted with an unsupported opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt_reg <= '0;
        else if (accept && !enc_legal && (illegal_cnt_reg != 16'hFFFF))
            illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
    end

`ifdef ENC_SELFCHECK_EN
    logic [6:0]  s1_op_reg;
    logic [4:0]  s1_rd_reg;
    logic [4:0]  s1_rs1_reg;
    logic [4:0]  s1_rs2_reg;
    logic [2:0]  s1_f3_reg;
    logic [6:0]  s1_f7_reg;
    logic [11:0] s1_imm12_reg;
    logic [19:0] s1_imm20_reg;
    logic        s1_legal_reg;
    logic        selfcheck_err_reg;

    logic [4:0]  dec_rd,  exp_rd;
    logic [4:0]  dec_rs1, exp_rs1;
    logic [4:0]  dec_rs2, exp_rs2;
    logic [2:0]  dec_f3,  exp_f3;
    logic [6:0]  dec_f7,  exp_f7;
    logic [11:0] dec_imm12, exp_imm12;
    logic [19:0] dec_imm20, exp_imm20;
    logic        sc_mismatch;

    // Source fields travel with the S1 word so it can be checked in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op_reg    <= '0;
            s1_rd_reg    <= '0;
            s1_rs1_reg   <= '0;
            s1_rs2_reg   <= '0;
            s1_f3_reg    <= '0;
            s1_f7_reg    <= '0;
            s1_imm12_reg <= '0;
            s1_imm20_reg <= '0;
            s1_legal_reg <= 1'b0;
        end else if (accept) begin
            s1_op_reg    <= bus.in_op;
            s1_rd_reg    <= bus.in_rd;
            s1_rs1_reg   <= bus.in_rs1;
            s1_rs2_reg   <= bus.in_rs2;
            s1_f3_reg    <= bus.in_funct3;
            s1_f7_reg    <= bus.in_funct7;
            s1_imm12_reg <= bus.in_imm12;
            s1_imm20_reg <= bus.in_imm20;
            s1_legal_reg <= enc_legal;
        end
    end

    // Re-decode the S1 word; fields unused by the opcode are zero on both sides.
    always_comb begin
        dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_f3 = '0; dec_f7 = '0;
        dec_imm12 = '0; dec_imm20 = '0;
        exp_rd = '0; exp_rs1 = '0; exp_rs2 = '0; exp_f3 = '0; exp_f7 = '0;
        exp_imm12 = '0; exp_imm20 = '0;
        case (s1_op_reg)
            OP_R: begin
                dec_rd  = s1_word_reg[11:7];  exp_rd  = s1_rd_reg;
                dec_rs1 = s1_word_reg[19:15]; exp_rs1 = s1_rs1_reg;
                dec_rs2 = s1_word_reg[24:20]; exp_rs2 = s1_rs2_reg;
                dec_f3  = s1_word_reg[14:12]; exp_f3  = s1_f3_reg;
                dec_f7  = s1_word_reg[31:25]; exp_f7  = s1_f7_reg;
            end
            OP_LOAD, OP_I: begin
                dec_rd    = s1_word_reg[11:7];  exp_rd    = s1_rd_reg;
                dec_rs1   = s1_word_reg[19:15]; exp_rs1   = s1_rs1_reg;
                dec_f3    = s1_word_reg[14:12]; exp_f3    = s1_f3_reg;
                dec_imm12 = s1_word_reg[31:20]; exp_imm12 = s1_imm12_reg;
            end
            OP_S: begin
                dec_rs1   = s1_word_reg[19:15]; exp_rs1 = s1_rs1_reg;
                dec_rs2   = s1_word_reg[24:20]; exp_rs2 = s1_rs2_reg;
                dec_f3    = s1_word_reg[14:12]; exp_f3  = s1_f3_reg;
                dec_imm12 = {s1_word_reg[31:25], s1_word_reg[11:7]};
                exp_imm12 = s1_imm12_reg;
            end
            OP_B: begin
                dec_rs1   = s1_word_reg[19:15]; exp_rs1 = s1_rs1_reg;
                dec_rs2   = s1_word_reg[24:20]; exp_rs2 = s1_rs2_reg;
                dec_f3    = s1_word_reg[14:12]; exp_f3  = s1_f3_reg;
                dec_imm12 = {s1_word_reg[31], s1_word_reg[7],
                             s1_word_reg[30:25], s1_word_reg[11:8]};
                exp_imm12 = s1_imm12_reg;
            end
            OP_JAL: begin
                dec_rd    = s1_word_reg[11:7]; exp_rd = s1_rd_reg;
                dec_imm20 = {s1_word_reg[31], s1_word_reg[18:12],
                             s1_word_reg[19], s1_word_reg[30:20]};
                exp_imm20 = s1_imm20_reg;
            end
            default: ;
        endcase
        sc_mismatch = ({s1_word_reg[6:0], dec_rd, dec_rs1, dec_rs2, dec_f3,
                        dec_f7, dec_imm12, dec_imm20} !=
                       {s1_op_reg, exp_rd, exp_rs1, exp_rs2, exp_f3,
                        exp_f7, exp_imm12, exp_imm20});
    end

    // Sticky round-trip error; illegal opcodes are not checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            selfcheck_err_reg <= 1'b0;
        else if (s1_valid_reg && s1_legal_reg && sc_mismatch)
            selfcheck_err_reg <= 1'b1;
    end

    assign selfcheck_err = selfcheck_err_reg;
`else
    assign selfcheck_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_pair_encoder.sv
// Directed bench for instr_pair_encoder: two instances (ADDR_W=8 and
// ADDR_W=2) see identical stimulus; written pairs are captured on the
// falling edge and compared against hand-computed words.
module tb_instr_pair_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        flush_done, flush_done2;
    logic [15:0] ill_cnt, ill_cnt2;
    logic        sc_err, sc_err2;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;

    logic [7:0]  q_addr[$];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [1:0]  q2_addr[$];

    always #5 clk = ~clk;

    instr_pair_encoder_if #(.ADDR_W(8)) bus ();
    instr_pair_encoder_if #(.ADDR_W(2)) bus2 ();

    instr_pair_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .flush_done(flush_done), .illegal_cnt(ill_cnt), .selfcheck_err(sc_err)
    );

    instr_pair_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .flush(flush),
        .flush_done(flush_done2), .illegal_cnt(ill_cnt2), .selfcheck_err(sc_err2)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_op     = bus.in_op;
    assign bus2.in_rd     = bus.in_rd;
    assign bus2.in_rs1    = bus.in_rs1;
    assign bus2.in_rs2    = bus.in_rs2;
    assign bus2.in_funct3 = bus.in_funct3;
    assign bus2.in_funct7 = bus.in_funct7;
    assign bus2.in_imm12  = bus.in_imm12;
    assign bus2.in_imm20  = bus.in_imm20;
    assign bus2.mem_ready = bus.mem_ready;

    // Capture every accepted pair write and every flush_done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_addr.delete(); q_a.delete(); q_b.delete(); q2_addr.delete();
        end else begin
            if (bus.mem_we && bus.mem_ready) begin
                q_addr.push_back(bus.mem_addr);
                q_a.push_back(bus.mem_data_a);
                q_b.push_back(bus.mem_data_b);
            end
            if (bus2.mem_we && bus2.mem_ready)
                q2_addr.push_back(bus2.mem_addr);
            if (flush_done)
                fd_cnt <= fd_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Offer one bundle and return one cycle after it is accepted.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [11:0] imm12, input logic [19:0] imm20, input logic with_flush);
        int n = 0;
        bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm12 = imm12; bus.in_imm20 = imm20;
        bus.in_valid = 1'b1;
        flush = with_flush;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 200) check_val("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        flush = 1'b0;
        $display("sent op=%07b rd=%0d rs1=%0d rs2=%0d imm12=%03h imm20=%05h flush=%0b",
                 op, rd, rs1, rs2, imm12, imm20, with_flush);
    endtask

    // I_IMME addi xk, x0, k : word = k<<20 | k<<7 | 0x13
    task automatic send_addi(input int k);
        send(7'b0010011, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 12'(k), 20'd0, 1'b0);
    endtask

    task automatic expect_pair(input string tag, input logic [7:0] addr,
                               input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        logic [7:0]  ga;
        logic [31:0] gwa, gwb;
        while (q_addr.size() == 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (q_addr.size() == 0) begin
            check_val({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            ga = q_addr.pop_front(); gwa = q_a.pop_front(); gwb = q_b.pop_front();
            $display("pair %s: addr=%0d a=%08h b=%08h", tag, ga, gwa, gwb);
            check_val({tag, "_addr"}, 32'(ga), 32'(addr));
            check_val({tag, "_a"}, gwa, a);
            check_val({tag, "_b"}, gwb, b);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    int          fd_base;
    int          changes;
    bit          snap;
    bit          saw_block;
    logic [31:0] snap_a, snap_b;
    logic [7:0]  snap_addr;
    logic [1:0]  exp2 [5];

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
        bus.in_imm12 = '0; bus.in_imm20 = '0; bus.mem_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_val("rst_data_a", bus.mem_data_a, 32'd0);
        check_val("rst_data_b", bus.mem_data_b, 32'd0);
        check_val("rst_flush_done", 32'(flush_done), 32'd0);
        check_val("rst_illegal_cnt", 32'(ill_cnt), 32'd0);
        check_val("rst_selfcheck", 32'(sc_err), 32'd0);
        do_reset();
        check_val("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // R_TYPE + I_IMME, latency: mem_we rises 2 cycles after the 2nd accept
        send(7'b0110011, 5'd5, 5'd6, 5'd7, 3'd0, 7'd32, 12'd0, 20'd0, 1'b0);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'h7FF, 20'd0, 1'b0);
        check_val("lat_we_early", 32'(bus.mem_we), 32'd0);
        @(posedge clk); #1;
        check_val("lat_we_high", 32'(bus.mem_we), 32'd1);
        expect_pair("r_i", 8'd0, 32'h407302B3, 32'h7FF00093);

        // S_TYPE + B_TYPE
        send(7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 12'h804, 20'd0, 1'b0);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'hFFF, 20'd0, 1'b0);
        expect_pair("s_b", 8'd1, 32'h80312223, 32'hFE208FE3);
        check_val("selfcheck_err", 32'(sc_err), 32'd0);

        // JAL with flush in the same cycle; imm20[0] lands in word bit 20
        fd_base = fd_cnt;
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 20'h80001, 1'b1);
        expect_pair("jal_flush", 8'd2, 32'h801000EF, 32'h00000013);
        repeat (6) @(posedge clk);
        #1;
        check_val("flush_done_pulses", 32'(fd_cnt - fd_base), 32'd1);

        // Illegal opcode then LOAD lw x2, 16(x1)
        send(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 12'd0, 20'd0, 1'b0);
        send(7'b0000011, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 12'h010, 20'd0, 1'b0);
        expect_pair("illegal_load", 8'd3, 32'h00000013, 32'h0100A103);
        check_val("illegal_cnt", 32'(ill_cnt), 32'd1);

        // Back-pressure: IMEM stalls while 6 bundles are offered
        do_reset();
        changes = 0; snap = 1'b0; saw_block = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++) send_addi(k);
            end
            begin
                bus.mem_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #1;
                    if (bus.mem_we) begin
                        if (!snap) begin
                            snap = 1'b1; snap_a = bus.mem_data_a;
                            snap_b = bus.mem_data_b; snap_addr = bus.mem_addr;
                        end else if (bus.mem_data_a !== snap_a || bus.mem_data_b !== snap_b ||
                                     bus.mem_addr !== snap_addr) begin
                            changes++;
                        end
                    end else if (snap) begin
                        changes++;
                    end
                    if (!bus.in_ready) saw_block = 1'b1;
                end
                check_val("stall_we_seen", 32'(snap), 32'd1);
                check_val("stall_hold_changes", 32'(changes), 32'd0);
                check_val("stall_in_ready_low", 32'(saw_block), 32'd1);
                bus.mem_ready = 1'b1;
            end
        join
        expect_pair("stall0", 8'd0, 32'h00100093, 32'h00200113);
        expect_pair("stall1", 8'd1, 32'h00300193, 32'h00400213);
        expect_pair("stall2", 8'd2, 32'h00500293, 32'h00600313);

        // Two more pairs: the ADDR_W=2 instance wraps its fifth pair to 0
        for (int k = 7; k <= 10; k++) send_addi(k);
        expect_pair("more3", 8'd3, 32'h00700393, 32'h00800413);
        expect_pair("more4", 8'd4, 32'h00900493, 32'h00A00513);
        exp2[0] = 2'd0; exp2[1] = 2'd1; exp2[2] = 2'd2; exp2[3] = 2'd3; exp2[4] = 2'd0;
        check_val("wrap_count", 32'(q2_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (q2_addr.size() > 0)
                check_val($sformatf("wrap_addr%0d", i), 32'(q2_addr.pop_front()), 32'(exp2[i]));
        end
        check_val("no_extra_pairs", 32'(q_addr.size()), 32'd0);

        // Reset while a word sits in slot A: it must be dropped
        send_addi(11);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_val("midrst_data_a", bus.mem_data_a, 32'd0);
        check_val("midrst_data_b", bus.mem_data_b, 32'd0);
        check_val("midrst_illegal", 32'(ill_cnt), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(7'b0110011, 5'd5, 5'd6, 5'd7, 3'd0, 7'd32, 12'd0, 20'd0, 1'b1);
        expect_pair("after_rst", 8'd0, 32'h407302B3, 32'h00000013);
        repeat (4) @(posedge clk);
        #1;
        check_val("after_rst_no_extra", 32'(q_addr.size()), 32'd0);
        check_val("final_selfcheck", 32'(sc_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
